// File: rtl/compute_seq_pkg.sv
// Shared constants, instruction fields and FSM state type
// for the compute unit program sequencer.
package compute_seq_pkg;

  localparam int SEQ_DEPTH   = 16;
  localparam int SEQ_INSTR_W = 16;
  localparam int SEQ_ITER_W  = 8;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_MOV = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;

  localparam int OP_LSB   = 12;
  localparam int TGT_LSB  = 8;
  localparam int SRC0_LSB = 4;
  localparam int SRC1_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/compute_sequencer_mem.sv
// Instruction buffer: flop array, one synchronous write
// port and one combinational read port.
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/compute_sequencer.sv
// Program sequencer: assembles byte pairs into a local
// buffer and issues them over valid/ready, optionally looped.
module compute_sequencer
  import compute_seq_pkg::*;
#(
  parameter int DEPTH   = SEQ_DEPTH,
  parameter int INSTR_W = SEQ_INSTR_W,
  parameter int ITER_W  = SEQ_ITER_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [7:0]               prog_byte,
  input  logic                     prog_clr,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ITER_W-1:0]        loop_count,
  output logic                     issue_valid,
  output logic [INSTR_W-1:0]       issue_instr,
  input  logic                     issue_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   prog_len,
  output logic [$clog2(DEPTH)-1:0] pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);

  seq_state_e r_state, w_next;

  logic [AW-1:0]      r_pc;
  logic [AW:0]        r_len;
  logic               r_phase_lo;
  logic [7:0]         r_hi;
  logic               r_ovf;
  logic [ITER_W-1:0]  r_iter;
  logic [ITER_W-1:0]  r_loop;
  logic               r_stop_pend;
  logic               r_abort;

  logic               w_idle;
  logic               w_run;
  logic               w_start;
  logic               w_full;
  logic               w_hs;
  logic               w_last;
  logic               w_stop_now;
  logic               w_wr;
  logic [INSTR_W-1:0] w_rdata;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_run      = (r_state == ST_RUN);
  assign w_start    = w_idle & start & ~prog_clr;
  assign w_full     = (r_len == LEN_FULL);
  assign w_hs       = w_run & issue_ready;
  assign w_last     = ({1'b0, r_pc} == (r_len - LEN_ONE));
  assign w_stop_now = stop | r_stop_pend;
  assign w_wr       = w_idle & prog_we & ~prog_clr & ~start
                    & r_phase_lo & ~w_full;

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_len[AW-1:0]),
    .i_wdata ({r_hi, prog_byte}),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start)
          w_next = (r_len == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (w_hs && (w_stop_now || (w_last && r_iter == r_loop)))
          w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_valid = 1'b0;
    issue_instr = '0;
    busy        = 1'b0;
    done        = 1'b0;
    aborted     = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        issue_valid = 1'b1;
        issue_instr = w_rdata;
        busy        = 1'b1;
      end
      ST_DONE: begin
        done    = 1'b1;
        aborted = r_abort;
      end
      default: ;
    endcase
  end

  // Byte assembly, counters and run bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_len       <= '0;
      r_phase_lo  <= 1'b0;
      r_hi        <= '0;
      r_ovf       <= 1'b0;
      r_iter      <= '0;
      r_loop      <= '0;
      r_stop_pend <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (prog_clr) begin
            r_len      <= '0;
            r_phase_lo <= 1'b0;
            r_ovf      <= 1'b0;
          end else if (start) begin
            r_phase_lo  <= 1'b0;
            r_pc        <= '0;
            r_iter      <= '0;
            r_loop      <= loop_count;
            r_stop_pend <= 1'b0;
            r_abort     <= 1'b0;
          end else if (prog_we) begin
            if (w_full) begin
              r_ovf <= 1'b1;
            end else if (!r_phase_lo) begin
              r_hi       <= prog_byte;
              r_phase_lo <= 1'b1;
            end else begin
              r_len      <= r_len + LEN_ONE;
              r_phase_lo <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_hs) begin
            if (w_stop_now) begin
              r_abort <= 1'b1;
            end else if (w_last) begin
              if (r_iter != r_loop) begin
                r_pc   <= '0;
                r_iter <= r_iter + ITER_W'(1);
              end
            end else begin
              r_pc <= r_pc + AW'(1);
            end
          end
        end
        ST_DONE: begin
          r_pc <= '0;
        end
        default: ;
      endcase
    end
  end

  assign overflow = r_ovf;
  assign prog_len = r_len;
  assign pc       = r_pc;

endmodule

// File: tb/tb_compute_sequencer.sv
// Randomised self-checking bench for compute_sequencer
// against a queue-based program/issue model.
module tb_compute_sequencer;

  localparam int DEPTH = 16;

  typedef logic [15:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [7:0]  prog_byte;
  logic        prog_clr;
  logic        start;
  logic        stop;
  logic [7:0]  loop_count;
  logic        issue_valid;
  logic [15:0] issue_instr;
  logic        issue_ready;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        overflow;
  logic [4:0]  prog_len;
  logic [3:0]  pc;

  compute_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_byte   (prog_byte),
    .prog_clr    (prog_clr),
    .start       (start),
    .stop        (stop),
    .loop_count  (loop_count),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .issue_ready (issue_ready),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .overflow    (overflow),
    .prog_len    (prog_len),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc = 0;
  logic [15:0] q_iss[$];
  int          q_pc[$];
  int          q_cyc[$];
  int          done_cnt;
  int          done_cyc;
  int          valid_cnt;
  logic        last_abort;

  // Observe accepted instructions and done pulses mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (issue_valid) valid_cnt++;
      if (issue_valid && issue_ready) begin
        q_iss.push_back(issue_instr);
        q_pc.push_back(int'(pc));
        q_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc   = cyc;
        last_abort = aborted;
      end
    end
  end

  function automatic wq_t expand(wq_t w, int lc);
    wq_t r;
    for (int p = 0; p <= lc; p++)
      foreach (w[i]) r.push_back(w[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q_iss.delete();
    q_pc.delete();
    q_cyc.delete();
    done_cnt   = 0;
    done_cyc   = 0;
    valid_cnt  = 0;
    last_abort = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    prog_we   = 1'b1;
    prog_byte = b;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic do_clear();
    prog_clr = 1'b1;
    tick();
    prog_clr = 1'b0;
  endtask

  task automatic load_prog(input wq_t w);
    foreach (w[i]) begin
      write_byte(w[i][15:8]);
      write_byte(w[i][7:0]);
    end
  endtask

  task automatic start_run(input int lc);
    loop_count = 8'(lc);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int max, input bit rnd,
                           output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < max) begin
      if (rnd) issue_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    issue_ready = 1'b1;
    ok = (done_cnt != 0);
  endtask

  wq_t base_prog;

  task automatic test_reset();
    rst = 1'b1;
    prog_we = 0; prog_byte = 0; prog_clr = 0; start = 0;
    stop = 0; loop_count = 0; issue_ready = 0;
    clear_mon();
    tick(); tick();
    n_checks++;
    if ({issue_valid, busy, done, aborted, overflow} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000",
               {issue_valid, busy, done, aborted, overflow});
    end
    n_checks++;
    if (prog_len !== 5'd0 || pc !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got len=%0d pc=%0d required 0/0",
               prog_len, pc);
    end
    n_checks++;
    if (issue_instr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_instr: got %h required 0000", issue_instr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    wq_t exp;
    bit ok;
    base_prog = '{16'h1105, 16'h1203, 16'h2012};
    exp = expand(base_prog, 0);
    do_clear();
    load_prog(base_prog);
    n_checks++;
    if (prog_len !== 5'd3) begin
      n_fail++;
      $display("FAIL basic_len: got %0d required 3", prog_len);
    end
    clear_mon();
    issue_ready = 1'b1;
    start_run(0);
    wait_done(50, 1'b0, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done: got no done required pulse");
    end
    n_checks++;
    if (q_iss.size() != exp.size()) begin
      n_fail++;
      $display("FAIL basic_count: got %0d required %0d",
               q_iss.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        n_checks++;
        if (q_iss[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL basic_instr[%0d]: got %h required %h",
                   i, q_iss[i], exp[i]);
        end
      end
      n_checks++;
      if (q_cyc[2] - q_cyc[0] != 2 || done_cyc != q_cyc[2] + 1) begin
        n_fail++;
        $display("FAIL basic_timing: got span=%0d done_gap=%0d required 2/1",
                 q_cyc[2] - q_cyc[0], done_cyc - q_cyc[2]);
      end
    end
    n_checks++;
    if (last_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_abort: got %b required 0", last_abort);
    end
  endtask

  task automatic test_loop();
    wq_t exp;
    bit ok;
    exp = expand(base_prog, 2);
    clear_mon();
    issue_ready = 1'b1;
    start_run(2);
    wait_done(100, 1'b0, ok);
    tick(); tick();
    n_checks++;
    if (!ok || done_cnt != 1) begin
      n_fail++;
      $display("FAIL loop_done: got %0d pulses required 1", done_cnt);
    end
    n_checks++;
    if (q_iss.size() != exp.size()) begin
      n_fail++;
      $display("FAIL loop_count: got %0d required %0d",
               q_iss.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        n_checks++;
        if (q_iss[i] !== exp[i] || q_pc[i] != i % 3) begin
          n_fail++;
          $display("FAIL loop_issue[%0d]: got %h@%0d required %h@%0d",
                   i, q_iss[i], q_pc[i], exp[i], i % 3);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    wq_t exp;
    bit ok;
    exp = expand(base_prog, 0);
    clear_mon();
    issue_ready = 1'b1;
    start_run(0);
    tick();
    issue_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (issue_valid !== 1'b1 || issue_instr !== 16'h1203) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b %h required v=1 1203",
                 k, issue_valid, issue_instr);
      end
      tick();
    end
    issue_ready = 1'b1;
    wait_done(50, 1'b0, ok);
    n_checks++;
    if (!ok || q_iss.size() != 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d issues required 3", q_iss.size());
    end else begin
      foreach (exp[i]) begin
        n_checks++;
        if (q_iss[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL bp_instr[%0d]: got %h required %h",
                   i, q_iss[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_stop();
    bit ok;
    clear_mon();
    issue_ready = 1'b1;
    start_run(0);
    tick();
    issue_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (issue_valid !== 1'b1 || issue_instr !== 16'h1203) begin
      n_fail++;
      $display("FAIL stop_hold: got v=%b %h required v=1 1203",
               issue_valid, issue_instr);
    end
    tick();
    issue_ready = 1'b1;
    wait_done(50, 1'b0, ok);
    n_checks++;
    if (!ok || last_abort !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_abort: got done=%0d aborted=%b required 1/1",
               done_cnt, last_abort);
    end
    n_checks++;
    if (q_iss.size() != 2) begin
      n_fail++;
      $display("FAIL stop_count: got %0d required 2", q_iss.size());
    end else begin
      n_checks++;
      if (q_iss[0] !== 16'h1105 || q_iss[1] !== 16'h1203) begin
        n_fail++;
        $display("FAIL stop_seq: got %h %h required 1105 1203",
                 q_iss[0], q_iss[1]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes[$];
    wq_t exp;
    bit ok;
    do_clear();
    for (int i = 0; i < 2 * DEPTH + 2; i++)
      bytes.push_back(8'($urandom));
    foreach (bytes[i]) write_byte(bytes[i]);
    for (int i = 0; i < DEPTH; i++)
      exp.push_back({bytes[2*i], bytes[2*i+1]});
    n_checks++;
    if (prog_len !== 5'd16 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full: got len=%0d ovf=%b required 16/1",
               prog_len, overflow);
    end
    clear_mon();
    issue_ready = 1'b1;
    start_run(0);
    wait_done(100, 1'b0, ok);
    n_checks++;
    if (!ok || q_iss.size() != DEPTH) begin
      n_fail++;
      $display("FAIL ovf_run: got %0d issues required %0d",
               q_iss.size(), DEPTH);
    end else begin
      foreach (exp[i]) begin
        n_checks++;
        if (q_iss[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL ovf_instr[%0d]: got %h required %h",
                   i, q_iss[i], exp[i]);
        end
      end
    end
    do_clear();
    n_checks++;
    if (prog_len !== 5'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got len=%0d ovf=%b required 0/0",
               prog_len, overflow);
    end
  endtask

  task automatic test_empty_start();
    clear_mon();
    issue_ready = 1'b1;
    start_run(0);
    n_checks++;
    if (done !== 1'b1 || issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done: got done=%b v=%b required 1/0",
               done, issue_valid);
    end
    tick(); tick();
    n_checks++;
    if (valid_cnt != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL empty_quiet: got valid=%0d done=%0d required 0/1",
               valid_cnt, done_cnt);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      wq_t w;
      wq_t exp;
      int len;
      int lc;
      bit ok;
      do_clear();
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) w.push_back(16'($urandom));
      load_prog(w);
      if ($urandom_range(0, 1) == 1) write_byte(8'($urandom));
      n_checks++;
      if (prog_len !== 5'(len)) begin
        n_fail++;
        $display("FAIL rnd%0d_len: got %0d required %0d",
                 it, prog_len, len);
      end
      lc = $urandom_range(0, 3);
      exp = expand(w, lc);
      clear_mon();
      issue_ready = 1'($urandom_range(0, 1));
      start_run(lc);
      wait_done(4000, 1'b1, ok);
      n_checks++;
      if (!ok || q_iss.size() != exp.size()) begin
        n_fail++;
        $display("FAIL rnd%0d_count: got %0d required %0d",
                 it, q_iss.size(), exp.size());
      end else begin
        foreach (exp[i]) begin
          n_checks++;
          if (q_iss[i] !== exp[i] || q_pc[i] != i % len) begin
            n_fail++;
            $display("FAIL rnd%0d_issue[%0d]: got %h@%0d required %h@%0d",
                     it, i, q_iss[i], q_pc[i], exp[i], i % len);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    do_clear();
    load_prog(base_prog);
    issue_ready = 1'b0;
    start_run(0);
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy: got %b required 1", busy);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (issue_valid !== 1'b0 || busy !== 1'b0 || prog_len !== 5'd0) begin
      n_fail++;
      $display("FAIL midrst: got v=%b busy=%b len=%0d required 0/0/0",
               issue_valid, busy, prog_len);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loop();
    test_backpressure();
    test_stop();
    test_overflow();
    test_empty_start();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
